// File: rtl/nios2_pio_pkg.sv
// -----------------------------------------------------------------------------
// nios2_pio_pkg
// Shared definitions for the Nios II parallel I/O slaves: the Avalon word
// addresses of the register map and the encodings of the edge-capture mode.
// -----------------------------------------------------------------------------
package nios2_pio_pkg;

    // Register map (word addresses within the slave)
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge-capture mode encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Final value of the post-reset arming counter: the synchroniser has to
    // be flushed and d_prev loaded before edges can be trusted.
    function automatic int arm_count_max(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/nios2_pio_sync.sv
// -----------------------------------------------------------------------------
// nios2_pio_sync
// WIDTH-bit multi-flop synchroniser for asynchronous inputs. Every stage
// resets to 0. dout is the last stage, so a change on din appears on dout
// after STAGES rising edges of clk.
//
// Ports:
//   clk      in   1      destination clock
//   reset_n  in   1      asynchronous active-low reset
//   din      in   WIDTH  asynchronous input bus
//   dout     out  WIDTH  synchronised bus
// -----------------------------------------------------------------------------
module nios2_pio_sync #(
    parameter int WIDTH  = 18,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // stage_r[0] is the metastability-catching flop; stage_r[STAGES-1] is safe
    logic [STAGES-1:0][WIDTH-1:0] stage_r;

    // Shift the input through the synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[STAGES-2:0], din};
        end
    end

    assign dout = stage_r[STAGES-1];

endmodule

// File: rtl/nios2_pio_in.sv
// -----------------------------------------------------------------------------
// nios2_pio_in
// Avalon-MM slave parallel input port for the Nios II system bus. The external
// bus is synchronised, per-bit edges are captured into a sticky write-1-to-
// clear register and a maskable level-high interrupt is raised.
//
// Register map (readdata bits above WIDTH read 0):
//   0 DATA     RO   synchronised in_port
//   1 DIR      RO   always 0 (input-only port)
//   2 IRQMASK  RW   interrupt enable per bit
//   3 EDGECAP  W1C  sticky edge capture per bit
//
// Ports:
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous active-low reset
//   address     in   2      word address
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data
//   in_port     in   WIDTH  external asynchronous input bus
//   readdata    out  32     read data, combinational from address
//   irq         out  1      registered level-high interrupt request
// -----------------------------------------------------------------------------
module nios2_pio_in
    import nios2_pio_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int ARM_MAX = arm_count_max(SYNC_STAGES);
    localparam int ARM_W   = $clog2(ARM_MAX + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_MAX);
    localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);

    logic [WIDTH-1:0] data_in_s;
    logic [WIDTH-1:0] d_prev_r;
    logic [ARM_W-1:0] arm_cnt_r;
    logic             armed_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] edge_armed_s;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] cap_r;
    logic [WIDTH-1:0] clr_s;
    logic             wr_s;
    logic             irq_r;
    logic [31:0]      rdata_s;
    logic             unused_wdata_s;

    // Writedata bits at or above WIDTH have no destination
    assign unused_wdata_s = ^writedata;

    nios2_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (in_port),
        .dout    (data_in_s)
    );

    assign wr_s    = chipselect && !write_n;
    assign armed_s = (arm_cnt_r == ARM_LAST);

    // Previous synchronised sample for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_prev_r <= '0;
        end else begin
            d_prev_r <= data_in_s;
        end
    end

    // Arming counter: holds edge detection off while the synchroniser fills,
    // so an input already high at reset release is not seen as an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_r <= '0;
        end else if (!armed_s) begin
            arm_cnt_r <= arm_cnt_r + ARM_ONE;
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    // Select the edge vector for the configured capture mode
    always_comb begin
        edge_s = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_s = data_in_s & ~d_prev_r;
            EDGE_FALL: edge_s = ~data_in_s & d_prev_r;
            EDGE_ANY:  edge_s = data_in_s ^ d_prev_r;
            default:   edge_s = data_in_s & ~d_prev_r;
        endcase
        if (armed_s) begin
            edge_armed_s = edge_s;
        end else begin
            edge_armed_s = '0;
        end
    end

    // Write-1-to-clear vector for EDGECAP
    always_comb begin
        clr_s = '0;
        if (wr_s && (address == ADDR_EDGECAP)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = '0;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r <= '0;
        end else if (wr_s && (address == ADDR_IRQMASK)) begin
            mask_r <= writedata[WIDTH-1:0];
        end else begin
            mask_r <= mask_r;
        end
    end

    // Sticky edge capture; a new edge overrides a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_r <= '0;
        end else begin
            cap_r <= (cap_r & ~clr_s) | edge_armed_s;
        end
    end

    // Level interrupt from enabled captured bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(cap_r & mask_r);
        end
    end

    assign irq = irq_r;

    // Zero-wait-state read mux; upper bits stay 0
    always_comb begin
        rdata_s = 32'd0;
        case (address)
            ADDR_DATA:    rdata_s[WIDTH-1:0] = data_in_s;
            ADDR_DIR:     rdata_s = 32'd0;
            ADDR_IRQMASK: rdata_s[WIDTH-1:0] = mask_r;
            ADDR_EDGECAP: rdata_s[WIDTH-1:0] = cap_r;
            default:      rdata_s = 32'd0;
        endcase
    end

    assign readdata = rdata_s;

endmodule

// File: doc/nios2_pio_in.md
Name: nios2_pio_in

Overview:
- Avalon-MM slave parallel *input* port; the input-direction counterpart of the team's output PIO on the Nios II system bus.
- Samples an external WIDTH-bit bus through a synchroniser.
- Captures per-bit edges into a sticky register and raises a maskable, level-sensitive IRQ to the Nios II interrupt controller.
- Zero-wait-state reads; combinational readdata.

Parameters:
- WIDTH, 18, number of input bits (1..32).
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (2..4).
- EDGE_TYPE, 0, edges captured: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  input  1  system clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  word address within the slave.
- chipselect  input  1  slave selected.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  external asynchronous input bus.
- readdata  output  32  read data, combinational from address.
- irq  output  1  interrupt request, registered, level-high.

Behaviour:
- Register map; unused upper readdata bits read 0:
  - 0 DATA: read-only, synchronised in_port. Writes ignored.
  - 1 DIRECTION: input-only port. Reads 0, writes ignored.
  - 2 IRQMASK: R/W, WIDTH bits. A write stores writedata[WIDTH-1:0].
  - 3 EDGECAP: sticky capture, read returns captured bits. Write is write-1-to-clear per bit.
- Write qualifier: chipselect && !write_n. Reads have no side effects; EDGECAP is not clear-on-read.
- Synchroniser: SYNC_STAGES flops per bit, all reset to 0. data_in is the last stage.
  - An in_port change is visible in DATA after SYNC_STAGES rising edges.
- Edge detect: d_prev <= data_in every cycle, reset 0.
  - rise = data_in & ~d_prev
  - fall = ~data_in & d_prev
  - The edge vector is selected by EDGE_TYPE.
- Arming: a counter runs 0..SYNC_STAGES+1 after reset release and saturates. Edge detection is gated off until the counter saturates.
  - Consequence: an input held high through reset produces no capture.
- EDGECAP update per bit, each cycle: next = (cap & ~clr) | edge, where clr = writedata bit when writing address 3.
  - Simultaneous edge and clear: the edge wins and the bit stays 1.
- irq: registered, irq <= |(EDGECAP & IRQMASK).
  - Asserts one cycle after the capture bit is set, or one cycle after the mask is written.
  - Deasserts one cycle after clear or mask.
- Latency, SYNC_STAGES=2, rising-edge mode, in_port bit rising before clock edge k:
  - DATA reads 1 from edge k+1.
  - EDGECAP bit set at edge k+2.
  - irq high at edge k+3.
- Pulses shorter than one clock period may be missed. This is not an error condition.
- Reset, whether asserted or mid-operation:
  - All of the following clear immediately: synchroniser, d_prev, arm counter, IRQMASK, EDGECAP, irq.
  - readdata reflects the cleared registers.
- Bits at or above WIDTH in writedata are ignored.

Decomposition:
- Shared package nios2_pio_pkg holds:
  - Address constants: ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - EDGE_TYPE encodings: EDGE_RISE, EDGE_FALL, EDGE_ANY.
- One natural sub-module, nios2_pio_sync: parameterised WIDTH × SYNC_STAGES synchroniser with asynchronous active-low reset. It is reusable by other input blocks.
- Edge detection, registers and IRQ stay in the top level.

Test Plan:
- Reset with in_port=18'h3FFFF held high → DATA reads 18'h3FFFF after 2 cycles; EDGECAP stays 0 indefinitely; irq=0.
- in_port bit 5 rises at edge k, IRQMASK=0 → DATA bit5=1 from k+1; EDGECAP=32'h20 at k+2; irq stays 0. Then write IRQMASK=32'h20 → irq=1 one cycle after the write.
- Write 32'h20 to EDGECAP → EDGECAP=0 next cycle, irq=0 the cycle after. Writing 32'h0 to EDGECAP leaves captured bits unchanged.
- Bit 3 rising edge detected in the same cycle as an EDGECAP write of 32'h8 → bit 3 remains 1 and irq stays or goes high.
- EDGE_TYPE=1: rising edge on bit 0 → no capture; falling edge → EDGECAP=1. EDGE_TYPE=2: both edges capture.
- reset_n asserted mid-operation with EDGECAP=32'h3 and irq=1 → all registers and irq are 0 immediately. After release, no spurious capture occurs during the arming window.
